// File: rtl/booth_pkg.sv
// Shared constants and FSM state encoding for the booth issue controller.
package booth_pkg;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_MUL_CYCLES = 8;
  localparam int DEF_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/booth_issue_ctrl_if.sv
// Operand-in, multiplier-side and result-out signals of the issue controller.
interface booth_issue_ctrl_if import booth_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_m;
  logic [WIDTH-1:0]   in_q;
  logic [WIDTH-1:0]   mul_m;
  logic [WIDTH-1:0]   mul_q;
  logic               mul_rst;
  logic [2*WIDTH-1:0] mul_result;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out_result;
  logic [WIDTH-1:0]   out_m;
  logic [WIDTH-1:0]   out_q;
  logic               busy;

  modport slave (
    input  in_valid, in_m, in_q, mul_result, out_ready,
    output in_ready, mul_m, mul_q, mul_rst, out_valid, out_result, out_m, out_q, busy
  );

  modport master (
    output in_valid, in_m, in_q, mul_result, out_ready,
    input  in_ready, mul_m, mul_q, mul_rst, out_valid, out_result, out_m, out_q, busy
  );

endinterface

// File: rtl/booth.sv
// Sequential radix-2 Booth multiplier; rst loads operands, result settles WIDTH cycles later.
module booth #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   m,
  input  logic [WIDTH-1:0]   q,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   r_a;
  logic [WIDTH:0]   r_m;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [CW-1:0]    r_cnt;

  // Accumulator is one bit wider so that subtracting the most negative m cannot overflow.
  always_comb begin
    case ({r_q[0], r_q1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_m   <= {m[WIDTH-1], m};
      r_q   <= q;
      r_q1  <= 1'b0;
      r_cnt <= CW'(WIDTH);
    end else if (r_cnt != '0) begin
      {r_a, r_q, r_q1} <= {w_sum[WIDTH], w_sum, r_q};
      r_cnt            <= r_cnt - CW'(1);
    end
  end

  assign result = {r_a[WIDTH-1:0], r_q};

endmodule

// File: rtl/booth_op_fifo.sv
// Small synchronous FIFO holding {m,q} operand pairs; async reset to empty.
module booth_op_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  output logic [DW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push && !o_full)  r_wptr <= r_wptr + PTR_ONE;
      if (i_pop  && !o_empty) r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !o_full) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rptr[AW-1:0]];
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

endmodule

// File: rtl/booth_issue_ctrl.sv
// Issue controller: queues operand pairs, starts the booth multiplier, waits a fixed budget, returns the product.
module booth_issue_ctrl import booth_pkg::*; #(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int MUL_CYCLES = DEF_MUL_CYCLES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst,
  booth_issue_ctrl_if.slave  bus
);

  state_t             r_state;
  state_t             w_next;
  logic [7:0]         r_cnt;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [2*WIDTH-1:0] w_head;
  logic [WIDTH-1:0]   r_mul_m;
  logic [WIDTH-1:0]   r_mul_q;
  logic [WIDTH-1:0]   r_out_m;
  logic [WIDTH-1:0]   r_out_q;
  logic [2*WIDTH-1:0] r_out_result;
  logic               r_out_valid;

  booth_op_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  ({bus.in_m, bus.in_q}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_push = bus.in_valid && bus.in_ready;

  // A pop happens from IDLE, or from HOLD on the result handshake, whenever a pair is queued.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD: w_next = RUN;
      RUN: begin
        if (r_cnt == 8'd0) w_next = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = LOAD;
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_mul_m      <= '0;
      r_mul_q      <= '0;
      r_out_m      <= '0;
      r_out_q      <= '0;
      r_out_result <= '0;
      r_out_valid  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_pop) begin
        r_mul_m <= w_head[2*WIDTH-1:WIDTH];
        r_mul_q <= w_head[WIDTH-1:0];
        r_out_m <= w_head[2*WIDTH-1:WIDTH];
        r_out_q <= w_head[WIDTH-1:0];
      end
      if (r_state == LOAD)     r_cnt <= 8'(MUL_CYCLES - 1);
      else if (r_state == RUN) r_cnt <= r_cnt - 8'd1;
      if (r_state == RUN && r_cnt == 8'd0) begin
        r_out_result <= bus.mul_result;
        r_out_valid  <= 1'b1;
      end else if (r_state == HOLD && bus.out_ready) begin
        r_out_valid  <= 1'b0;
      end
    end
  end

  // Reset holds the multiplier in its start state and closes the input side immediately.
  assign bus.in_ready   = !rst && !w_full;
  assign bus.mul_rst    = rst || (r_state == LOAD);
  assign bus.mul_m      = r_mul_m;
  assign bus.mul_q      = r_mul_q;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_result = r_out_result;
  assign bus.out_m      = r_out_m;
  assign bus.out_q      = r_out_q;
  assign bus.busy       = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_booth_issue_ctrl.sv
// Directed and randomized bench for booth_issue_ctrl paired with the booth multiplier.
module tb_booth_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          mulRstRun = 0;
  logic [15:0] gotQ[$];
  int          gotCyc[$];
  int          accCyc;
  int          c0;
  int          n;
  logic        spurious;
  logic [15:0] sb[$];
  int          sent;
  int          recv;
  int          budget;
  logic        w;
  logic [15:0] expv;
  logic [15:0] exp3 [4];
  logic [15:0] exp4 [3];

  booth_issue_ctrl_if bus ();

  booth_issue_ctrl u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  booth #(.WIDTH(4)) u_booth (
    .clk    (clk),
    .rst    (bus.mul_rst),
    .m      (bus.mul_m),
    .q      (bus.mul_q),
    .result (bus.mul_result)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] m, input logic [3:0] q,
                               input logic ordy);
    bus.in_valid  = v;
    bus.in_m      = m;
    bus.in_q      = q;
    bus.out_ready = ordy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    checks++;
    assert (obs === expd) else begin
      failures++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expd);
    end
  endtask

  function automatic logic [7:0] refMul(input logic [3:0] a, input logic [3:0] b);
    int ia;
    int ib;
    ia = int'($signed(a));
    ib = int'($signed(b));
    return 8'(ia * ib);
  endfunction

  // One operation from an idle controller with out_ready already high.
  task automatic doSingle(input string tag, input logic [3:0] m, input logic [3:0] q,
                          input logic [31:0] expRes);
    int k;
    checkOutput({tag, "_ready"}, 32'(bus.in_ready), 'h1);
    applyStimulus(1'b1, m, q, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 40) begin
      tick();
      k++;
    end
    checkOutput({tag, "_lat"}, k, 'd10);
    checkOutput({tag, "_res"}, 32'(bus.out_result), expRes);
    checkOutput({tag, "_echo"}, 32'({bus.out_m, bus.out_q}), 32'({m, q}));
    tick();
    checkOutput({tag, "_done"}, 32'(bus.out_valid), 'h0);
  endtask

  // Runs until n results have been handshaken, releasing in_valid once its pair is accepted.
  task automatic collect(input string tag, input int num, input int limit);
    int b;
    logic acc;
    b = 0;
    gotQ.delete();
    gotCyc.delete();
    accCyc = -1;
    while (gotQ.size() < num && b < limit) begin
      if (bus.out_valid && bus.out_ready) begin
        gotQ.push_back({bus.out_result, bus.out_m, bus.out_q});
        gotCyc.push_back(cyc);
      end
      if (gotQ.size() < num) begin
        acc = bus.in_valid && bus.in_ready;
        tick();
        b++;
        if (acc) begin
          bus.in_valid = 1'b0;
          accCyc = cyc;
        end
      end
    end
    checkOutput({tag, "_count"}, gotQ.size(), num);
  endtask

  // Every start pulse outside reset must be exactly one cycle wide.
  always @(negedge clk) begin
    if (rst) mulRstRun = 0;
    else if (bus.mul_rst) mulRstRun++;
    else if (mulRstRun != 0) begin
      checkOutput("mulrst_width", mulRstRun, 'd1);
      mulRstRun = 0;
    end
  end

  initial begin
    applyStimulus(1'b0, 4'h0, 4'h0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    checkOutput("rst_mulrst", 32'(bus.mul_rst), 'h1);
    checkOutput("rst_inready", 32'(bus.in_ready), 'h0);
    checkOutput("rst_outvalid", 32'(bus.out_valid), 'h0);
    checkOutput("rst_regs", 32'({bus.mul_m, bus.mul_q, bus.out_result, bus.out_m, bus.out_q}), 'h0);
    checkOutput("rst_busy", 32'(bus.busy), 'h0);
    rst = 1'b0;
    #1;
    checkOutput("rel_inready", 32'(bus.in_ready), 'h1);
    checkOutput("rel_mulrst", 32'(bus.mul_rst), 'h0);

    $display("[TB] single operations");
    doSingle("t1_3x2", 4'h3, 4'h2, 'h06);
    doSingle("t1_m3x2", 4'hD, 4'h2, 'hFA);
    doSingle("t1_m4xm3", 4'hC, 4'hD, 'h0C);
    doSingle("t1_0x5", 4'h0, 4'h5, 'h00);

    $display("[TB] corner operands");
    doSingle("t2_m8xm8", 4'h8, 4'h8, 'h40);
    doSingle("t2_m8x7", 4'h8, 4'h7, 'hC8);
    doSingle("t2_7x7", 4'h7, 4'h7, 'h31);

    $display("[TB] back-to-back pairs");
    exp3 = '{16'h01_1_1, 16'h06_2_3, 16'hFB_F_5, 16'h04_E_E};
    applyStimulus(1'b1, 4'h1, 4'h1, 1'b1);
    tick();
    c0 = cyc;
    applyStimulus(1'b1, 4'h2, 4'h3, 1'b1);
    tick();
    applyStimulus(1'b1, 4'hF, 4'h5, 1'b1);
    tick();
    checkOutput("t3_full", 32'(bus.in_ready), 'h0);
    applyStimulus(1'b1, 4'hE, 4'hE, 1'b1);
    collect("t3", 4, 100);
    for (int i = 0; i < 4; i++) begin
      checkOutput("t3_order", 32'(gotQ[i]), 32'(exp3[i]));
      checkOutput("t3_time", gotCyc[i] - c0, 10 + 10 * i);
    end
    checkOutput("t3_reaccept", accCyc - c0, 'd12);
    tick();

    $display("[TB] backpressure");
    exp4 = '{16'h09_3_3, 16'hF1_B_3, 16'hD6_6_9};
    applyStimulus(1'b1, 4'h3, 4'h3, 1'b0);
    tick();
    c0 = cyc;
    applyStimulus(1'b1, 4'hB, 4'h3, 1'b0);
    tick();
    applyStimulus(1'b1, 4'h6, 4'h9, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput("t4_lat", cyc - c0, 'd10);
    checkOutput("t4_full", 32'(bus.in_ready), 'h0);
    for (int i = 0; i < 30; i++) begin
      tick();
      checkOutput("t4_hold",
        32'({bus.out_valid, bus.out_result, bus.out_m, bus.out_q, bus.mul_m, bus.mul_q, bus.in_ready}),
        32'({1'b1, 8'h09, 4'h3, 4'h3, 4'h3, 4'h3, 1'b0}));
    end
    bus.out_ready = 1'b1;
    collect("t4", 3, 100);
    for (int i = 0; i < 3; i++) checkOutput("t4_order", 32'(gotQ[i]), 32'(exp4[i]));
    tick();
    checkOutput("t4_idle", 32'(bus.busy), 'h0);

    $display("[TB] reset during RUN");
    applyStimulus(1'b1, 4'h5, 4'h5, 1'b1);
    tick();
    applyStimulus(1'b1, 4'h4, 4'h4, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("t5_busy_pre", 32'(bus.busy), 'h1);
    rst = 1'b1;
    #1;
    checkOutput("t5_mulrst", 32'(bus.mul_rst), 'h1);
    checkOutput("t5_outvalid", 32'(bus.out_valid), 'h0);
    checkOutput("t5_inready", 32'(bus.in_ready), 'h0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("t5_rel_inready", 32'(bus.in_ready), 'h1);
    checkOutput("t5_rel_mulrst", 32'(bus.mul_rst), 'h0);
    checkOutput("t5_rel_busy", 32'(bus.busy), 'h0);
    spurious = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      spurious = spurious | bus.out_valid | bus.busy;
    end
    checkOutput("t5_quiet", 32'(spurious), 'h0);
    doSingle("t5_2x3", 4'h2, 4'h3, 'h06);

    $display("[TB] random traffic");
    sent = 0;
    recv = 0;
    budget = 0;
    bus.in_valid = 1'b0;
    while (recv < 1000 && budget < 40000) begin
      if (!bus.in_valid && sent < 1000 && $urandom_range(0, 1) == 1) begin
        bus.in_m     = 4'($urandom_range(0, 15));
        bus.in_q     = 4'($urandom_range(0, 15));
        bus.in_valid = 1'b1;
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        expv = (sb.size() != 0) ? sb.pop_front() : 16'hxxxx;
        checkOutput("t6_result", 32'({bus.out_result, bus.out_m, bus.out_q}), 32'(expv));
        recv++;
      end
      w = bus.in_valid && bus.in_ready;
      if (w) begin
        sb.push_back({refMul(bus.in_m, bus.in_q), bus.in_m, bus.in_q});
        sent++;
      end
      tick();
      budget++;
      if (w) bus.in_valid = 1'b0;
    end
    checkOutput("t6_count", recv, 'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
